rr_burst_arbiter: RTL and testbench

//  Shares one single-issue resource between two requesters. Grants are

---
 rtl/rr_burst_arbiter_pkg.sv | 27 ++
 rtl/rr_burst_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_burst_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types for the round-robin burst arbiter: grant and priority FSM
// encodings plus a decoder from grant state to the one-hot grant vector.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } grant_state_t;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_t;

    function automatic logic [1:0] grant_onehot(input grant_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts and a stall watchdog.
// A priority FSM remembers who goes next; the grant FSM reads it on contention.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       req,
    input  logic                             res_ready,
    output logic [1:0]                       gnt,
    output logic                             res_valid,
    output logic                             owner,
    output logic [$clog2(MAX_BURST+1)-1:0]   beat_cnt,
    output logic                             timeout_err
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int SCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BEAT   = BCW'(MAX_BURST - 1);
    localparam logic [SCW-1:0] STALL_LIMIT = SCW'(TIMEOUT - 1);

    grant_state_t   state_q, state_d;
    prio_t          prio_q, prio_d;
    logic [BCW-1:0] beat_cnt_q;
    logic [SCW-1:0] stall_q;
    logic           timeout_err_q;

    logic owner_bit;
    logic in_grant;
    logic req_own;
    logic beat;
    logic last_beat;
    logic stall_rel;
    logic release_w;

    assign owner_bit = (state_q == GRANT1);
    assign in_grant  = (state_q != IDLE);
    assign req_own   = req[owner_bit];
    assign beat      = in_grant & req_own & res_ready;
    assign last_beat = beat & (beat_cnt_q == LAST_BEAT);
    assign stall_rel = in_grant & ~res_ready & (stall_q == STALL_LIMIT);
    // All three release causes collapse into one event so the priority flips once.
    assign release_w = in_grant & (~req_own | last_beat | stall_rel);

    // Grant FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req == 2'b11) begin
                    state_d = (prio_q == PRIO0) ? GRANT0 : GRANT1;
                end else if (req[0]) begin
                    state_d = GRANT0;
                end else if (req[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (release_w) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (release_w) begin
            prio_d = owner_bit ? PRIO0 : PRIO1;
        end
    end

    // Beat and stall counters; both restart with every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if (!in_grant || release_w) begin
            beat_cnt_q <= '0;
        end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!in_grant || release_w || beat) begin
            stall_q <= '0;
        end else if (!res_ready) begin
            stall_q <= stall_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= stall_rel;
        end
    end

    assign gnt         = grant_onehot(state_q);
    assign owner       = owner_bit;
    assign res_valid   = |(gnt & req);
    assign beat_cnt    = beat_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: default instance (MAX_BURST=4, TIMEOUT=8)
// plus a MAX_BURST=1 instance for the strict-alternation case.
module tb_rr_burst_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic       res_ready;
    logic [1:0] gnt;
    logic       res_valid;
    logic       owner;
    logic [2:0] beat_cnt;
    logic       timeout_err;

    logic [1:0] req_b;
    logic       res_ready_b;
    logic [1:0] gnt_b;
    logic       res_valid_b;
    logic       owner_b;
    logic [0:0] beat_cnt_b;
    logic       timeout_err_b;

    int checks;
    int errors;

    rr_burst_arbiter #(.MAX_BURST(4), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .res_ready   (res_ready),
        .gnt         (gnt),
        .res_valid   (res_valid),
        .owner       (owner),
        .beat_cnt    (beat_cnt),
        .timeout_err (timeout_err)
    );

    rr_burst_arbiter #(.MAX_BURST(1), .TIMEOUT(8)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .req         (req_b),
        .res_ready   (res_ready_b),
        .gnt         (gnt_b),
        .res_valid   (res_valid_b),
        .owner       (owner_b),
        .beat_cnt    (beat_cnt_b),
        .timeout_err (timeout_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = 2'b00;
        res_ready   = 1'b1;
        req_b       = 2'b00;
        res_ready_b = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 2'b11;
        step();
        checks++;
        if (gnt !== 2'b00 || owner !== 1'b0 || beat_cnt !== 3'd0 ||
            timeout_err !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state gnt=%b owner=%b cnt=%0d terr=%b valid=%b expected all zero",
                     gnt, owner, beat_cnt, timeout_err, res_valid);
        end
        $display("test_reset: gnt=%b owner=%b cnt=%0d", gnt, owner, beat_cnt);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [11];
        int         exp_c [11];
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        exp_c = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0};
        do_reset();
        req       = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (gnt !== exp_g[i] || beat_cnt !== 3'(exp_c[i]) ||
                owner !== exp_g[i][1] || res_valid !== (|exp_g[i])) begin
                errors++;
                $display("FAIL contention cyc=%0d gnt=%b cnt=%0d owner=%b valid=%b expected gnt=%b cnt=%0d",
                         i, gnt, beat_cnt, owner, res_valid, exp_g[i], exp_c[i]);
            end
            $display("test_contention cyc=%0d gnt=%b cnt=%0d", i, gnt, beat_cnt);
        end
    endtask

    task automatic test_single_requester();
        logic [1:0] exp_g [6];
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        do_reset();
        req       = 2'b01;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (gnt !== exp_g[i]) begin
                errors++;
                $display("FAIL single_req cyc=%0d gnt=%b expected %b", i, gnt, exp_g[i]);
            end
            $display("test_single_requester cyc=%0d gnt=%b cnt=%0d", i, gnt, beat_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req       = 2'b01;
        res_ready = 1'b0;
        step();
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gnt !== 2'b01 || timeout_err !== 1'b0 || res_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d gnt=%b terr=%b valid=%b expected gnt=01 terr=0 valid=1",
                         i, gnt, timeout_err, res_valid);
            end
            $display("test_timeout stall cyc=%0d gnt=%b terr=%b", i, gnt, timeout_err);
            step();
        end
        checks++;
        if (gnt !== 2'b00 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_release gnt=%b terr=%b expected gnt=00 terr=1", gnt, timeout_err);
        end
        $display("test_timeout release gnt=%b terr=%b", gnt, timeout_err);
        step();
        checks++;
        if (gnt !== 2'b10 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout gnt=%b terr=%b expected gnt=10 terr=0", gnt, timeout_err);
        end
        $display("test_timeout regrant gnt=%b terr=%b", gnt, timeout_err);
    endtask

    task automatic test_req_drop();
        do_reset();
        req       = 2'b01;
        res_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (beat_cnt !== 3'd2 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL drop_cnt cnt=%0d gnt=%b expected cnt=2 gnt=01", beat_cnt, gnt);
        end
        req = 2'b10;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_valid valid=%b expected 0", res_valid);
        end
        step();
        checks++;
        if (gnt !== 2'b00 || beat_cnt !== 3'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_release gnt=%b cnt=%0d terr=%b expected 00/0/0", gnt, beat_cnt, timeout_err);
        end
        req = 2'b11;
        step();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL drop_prio gnt=%b expected 10", gnt);
        end
        $display("test_req_drop gnt=%b owner=%b", gnt, owner);
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        req       = 2'b10;
        res_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (gnt !== 2'b10 || beat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset gnt=%b cnt=%0d expected 10/2", gnt, beat_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || beat_cnt !== 3'd0 || owner !== 1'b0 ||
            res_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset gnt=%b cnt=%0d owner=%b valid=%b expected all zero",
                     gnt, beat_cnt, owner, res_valid);
        end
        step();
        req   = 2'b11;
        reset = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant gnt=%b expected 01", gnt);
        end
        $display("test_mid_burst_reset gnt=%b", gnt);
    endtask

    task automatic test_single_beat();
        logic [1:0] exp_g [7];
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        do_reset();
        req_b       = 2'b11;
        res_ready_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (gnt_b !== exp_g[i] || beat_cnt_b !== 1'b0) begin
                errors++;
                $display("FAIL single_beat cyc=%0d gnt=%b cnt=%0d expected gnt=%b cnt=0",
                         i, gnt_b, beat_cnt_b, exp_g[i]);
            end
            $display("test_single_beat cyc=%0d gnt=%b", i, gnt_b);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        req         = 2'b00;
        res_ready   = 1'b1;
        req_b       = 2'b00;
        res_ready_b = 1'b1;
        test_reset();
        test_contention();
        test_single_requester();
        test_timeout();
        test_req_drop();
        test_mid_burst_reset();
        test_single_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
